// File: rtl/alu_issue_stage.sv
// alu_issue_stage
//   Execute-stage issue/capture block of the 5-stage RV32I pipeline. Holds the
//   ID/EX register, selects (and optionally forwards) ALU operands, drives the
//   external combinational ALU and captures its result into the EX/MEM register.
//
// Ports
//   clk_i, rst_i           clock, synchronous active-high reset
//   flush_i                kill the ID/EX entry (a beat offered this cycle is dropped)
//   id_valid_i/id_ready_o  decode-side handshake; id_ready_o is combinational
//   id_*_i                 decoded instruction fields (pc, rs data, imm, addrs, selects, op, wb_en)
//   operand_a_o/b_o, alu_op_o   combinational drive to the ALU
//   result_alu_i           combinational ALU result
//   ex_valid_o/ex_ready_i  memory-side handshake
//   ex_result_o, ex_rd_addr_o, ex_wb_en_o   captured EX/MEM entry
//   wb_en_i, wb_rd_addr_i, wb_data_i        writeback port (used only with forwarding)
//
// Configuration
//   ALU_FWD_EN  when defined, enables EX/MEM->EX forwarding and WB write-through
//               into the held ID/EX operands. Undefined: operands come straight
//               from the captured register-file values and wb_* is ignored.
module alu_issue_stage #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              id_valid_i,
    output logic              id_ready_o,
    input  logic [XLEN-1:0]   id_pc_i,
    input  logic [XLEN-1:0]   id_rs1_data_i,
    input  logic [XLEN-1:0]   id_rs2_data_i,
    input  logic [XLEN-1:0]   id_imm_i,
    input  logic [REG_AW-1:0] id_rs1_addr_i,
    input  logic [REG_AW-1:0] id_rs2_addr_i,
    input  logic [REG_AW-1:0] id_rd_addr_i,
    input  logic              id_asel_i,
    input  logic              id_bsel_i,
    input  logic [3:0]        id_alu_op_i,
    input  logic              id_wb_en_i,
    output logic [XLEN-1:0]   operand_a_o,
    output logic [XLEN-1:0]   operand_b_o,
    output logic [3:0]        alu_op_o,
    input  logic [XLEN-1:0]   result_alu_i,
    output logic              ex_valid_o,
    input  logic              ex_ready_i,
    output logic [XLEN-1:0]   ex_result_o,
    output logic [REG_AW-1:0] ex_rd_addr_o,
    output logic              ex_wb_en_o,
    input  logic              wb_en_i,
    input  logic [REG_AW-1:0] wb_rd_addr_i,
    input  logic [XLEN-1:0]   wb_data_i
);

    localparam int unsigned OP_W = 4;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [XLEN-1:0]   imm;
        logic [REG_AW-1:0] rs1_addr;
        logic [REG_AW-1:0] rs2_addr;
        logic [REG_AW-1:0] rd_addr;
        logic              asel;
        logic              bsel;
        logic [OP_W-1:0]   op;
        logic              wb_en;
    } idex_t;

    typedef struct packed {
        logic [XLEN-1:0]   result;
        logic [REG_AW-1:0] rd_addr;
        logic              wb_en;
    } exmem_t;

    logic            idex_valid_q, idex_valid_d;
    idex_t           idex_q, idex_d;
    logic            ex_valid_q, ex_valid_d;
    exmem_t          ex_q, ex_d;

    logic            advance;
    logic            id_accept;
    logic            ex_load;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;

    // Pipeline handshake: EX/MEM can take a new entry when empty or draining.
    assign advance    = ~ex_valid_q | ex_ready_i;
    assign id_ready_o = ~idex_valid_q | advance;
    // Flush wins over a beat offered in the same cycle.
    assign id_accept  = id_valid_i & id_ready_o & ~flush_i;
    // A flushed ID/EX entry must not reach EX/MEM; a bubble is loaded instead.
    assign ex_load    = advance & idex_valid_q & ~flush_i;

`ifdef ALU_FWD_EN
    // Replace a source value with the WB data when WB targets that (non-x0) register.
    function automatic logic [XLEN-1:0] wb_merge(
        input logic [XLEN-1:0]   data,
        input logic [REG_AW-1:0] addr,
        input logic              wen,
        input logic [REG_AW-1:0] waddr,
        input logic [XLEN-1:0]   wdata
    );
        return (wen && (waddr == addr) && (addr != '0)) ? wdata : data;
    endfunction

    // EX/MEM result takes priority over the held/WB-updated value; x0 never forwards.
    always_comb begin
        fwd_rs1 = idex_q.rs1_data;
        fwd_rs2 = idex_q.rs2_data;
        if (ex_valid_q && ex_q.wb_en && (ex_q.rd_addr == idex_q.rs1_addr) && (idex_q.rs1_addr != '0)) begin
            fwd_rs1 = ex_q.result;
        end
        if (ex_valid_q && ex_q.wb_en && (ex_q.rd_addr == idex_q.rs2_addr) && (idex_q.rs2_addr != '0)) begin
            fwd_rs2 = ex_q.result;
        end
    end
`else
    assign fwd_rs1 = idex_q.rs1_data;
    assign fwd_rs2 = idex_q.rs2_data;

    // Source indices and the WB port only matter when forwarding is built in.
    logic unused_fwd;
    assign unused_fwd = ^{wb_en_i, wb_rd_addr_i, wb_data_i, idex_q.rs1_addr, idex_q.rs2_addr};
`endif

    // ALU drive
    assign operand_a_o = idex_q.asel ? idex_q.pc  : fwd_rs1;
    assign operand_b_o = idex_q.bsel ? idex_q.imm : fwd_rs2;
    assign alu_op_o    = idex_q.op;

    // EX/MEM outputs
    assign ex_valid_o   = ex_valid_q;
    assign ex_result_o  = ex_q.result;
    assign ex_rd_addr_o = ex_q.rd_addr;
    assign ex_wb_en_o   = ex_q.wb_en;

    // Next state for ID/EX and EX/MEM
    always_comb begin
        idex_valid_d = idex_valid_q;
        idex_d       = idex_q;
        ex_valid_d   = ex_valid_q;
        ex_d         = ex_q;

`ifdef ALU_FWD_EN
        // A held entry picks up WB writes that land while it waits.
        if (idex_valid_q) begin
            idex_d.rs1_data = wb_merge(idex_q.rs1_data, idex_q.rs1_addr, wb_en_i, wb_rd_addr_i, wb_data_i);
            idex_d.rs2_data = wb_merge(idex_q.rs2_data, idex_q.rs2_addr, wb_en_i, wb_rd_addr_i, wb_data_i);
        end
`endif

        if (flush_i) begin
            idex_valid_d = 1'b0;
        end else if (id_accept) begin
            idex_valid_d    = 1'b1;
            idex_d.pc       = id_pc_i;
            idex_d.imm      = id_imm_i;
            idex_d.rs1_addr = id_rs1_addr_i;
            idex_d.rs2_addr = id_rs2_addr_i;
            idex_d.rd_addr  = id_rd_addr_i;
            idex_d.asel     = id_asel_i;
            idex_d.bsel     = id_bsel_i;
            idex_d.op       = id_alu_op_i;
            idex_d.wb_en    = id_wb_en_i;
`ifdef ALU_FWD_EN
            // Register-file write-through for a WB landing on the load edge.
            idex_d.rs1_data = wb_merge(id_rs1_data_i, id_rs1_addr_i, wb_en_i, wb_rd_addr_i, wb_data_i);
            idex_d.rs2_data = wb_merge(id_rs2_data_i, id_rs2_addr_i, wb_en_i, wb_rd_addr_i, wb_data_i);
`else
            idex_d.rs1_data = id_rs1_data_i;
            idex_d.rs2_data = id_rs2_data_i;
`endif
        end else if (advance) begin
            idex_valid_d = 1'b0;
        end

        // Bubbles leave the captured fields untouched.
        if (advance) begin
            ex_valid_d = ex_load;
            if (ex_load) begin
                ex_d.result  = result_alu_i;
                ex_d.rd_addr = idex_q.rd_addr;
                ex_d.wb_en   = idex_q.wb_en;
            end
        end
    end

    // State registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idex_valid_q <= 1'b0;
            idex_q       <= '0;
            ex_valid_q   <= 1'b0;
            ex_q         <= '0;
        end else begin
            idex_valid_q <= idex_valid_d;
            idex_q       <= idex_d;
            ex_valid_q   <= ex_valid_d;
            ex_q         <= ex_d;
        end
    end

endmodule
